// File: rtl/spi_reg_target_if.sv
// Signal bundle between an SPI controller/fabric agent and spi_reg_target.
// The master side drives the SPI lines and fabric read address; the slave is the target.
interface spi_reg_target_if #(
    parameter int unsigned REG_WIDTH = 8
);
    logic                 spi_clk;
    logic                 serial_in;
    logic                 serial_out;
    logic [7:0]           reg_rd_addr;
    logic [REG_WIDTH-1:0] reg_rd_data;
    logic                 reg_wr_pulse;
    logic [7:0]           reg_wr_addr;
    logic [REG_WIDTH-1:0] reg_wr_data;
    logic                 busy;
    logic                 frame_error;

    modport master (
        output spi_clk, serial_in, reg_rd_addr,
        input  serial_out, reg_rd_data, reg_wr_pulse, reg_wr_addr, reg_wr_data,
               busy, frame_error
    );

    modport slave (
        input  spi_clk, serial_in, reg_rd_addr,
        output serial_out, reg_rd_data, reg_wr_pulse, reg_wr_addr, reg_wr_data,
               busy, frame_error
    );
endinterface

// File: rtl/spi_reg_target.sv
// SPI mode-0 register-bank target: oversamples the SPI lines, decodes single-byte
// write and burst read frames, and exposes a fabric read port plus write strobe.
module spi_reg_target #(
    parameter int unsigned REG_WIDTH      = 8,
    parameter int unsigned NUM_REGS       = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              rst,
    spi_reg_target_if.slave  bus
);
    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned BW = $clog2(REG_WIDTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned CW = 7;

    typedef enum logic [1:0] {RX_HDR, RX_ADDR, RX_WDATA, TX_RDATA} state_t;

    state_t               state, state_next;
    logic [2:0]           sclk_sync;
    logic [1:0]           sin_sync;
    logic                 rise_c, fall_c, byte_done_c, active_c, timeout_c;
    logic                 commit_c, load_first_c, load_next_c;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic [REG_WIDTH-2:0] shift_q;
    logic [REG_WIDTH-1:0] byte_c, hdr_q, tx_q;
    logic [AW-1:0]        addr_q;
    logic [CW-1:0]        rem_q;
    logic [TW-1:0]        timer_q;
    logic [REG_WIDTH-1:0] regs [NUM_REGS];
    logic                 serial_out_q, busy_q, wr_pulse_q, frame_error_q;
    logic [7:0]           wr_addr_q;
    logic [REG_WIDTH-1:0] wr_data_q;

    // Two-flop synchronisers; sclk_sync[2] is the edge-detect history tap.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            sin_sync  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[1:0], bus.spi_clk};
            sin_sync  <= {sin_sync[0], bus.serial_in};
        end
    end

    assign rise_c      = sclk_sync[1] & ~sclk_sync[2];
    assign fall_c      = ~sclk_sync[1] & sclk_sync[2];
    assign byte_c      = {shift_q, sin_sync[1]};
    assign byte_done_c = rise_c && (bit_cnt == BW'(REG_WIDTH - 1));
    assign active_c    = (state != RX_HDR) || (bit_cnt != '0);
    assign timeout_c   = active_c && !rise_c && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= RX_HDR;
        else     state <= state_next;
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        commit_c     = 1'b0;
        load_first_c = 1'b0;
        load_next_c  = 1'b0;
        if (timeout_c) begin
            state_next   = RX_HDR;
            bit_cnt_next = '0;
        end else if (rise_c) begin
            bit_cnt_next = byte_done_c ? '0 : BW'(bit_cnt + 1'b1);
            if (byte_done_c) begin
                case (state)
                    RX_HDR:   state_next = RX_ADDR;
                    RX_ADDR: begin
                        if (hdr_q[REG_WIDTH-1]) begin
                            state_next = RX_WDATA;
                        end else begin
                            state_next   = TX_RDATA;
                            load_first_c = 1'b1;
                        end
                    end
                    RX_WDATA: begin
                        state_next = RX_HDR;
                        commit_c   = 1'b1;
                    end
                    TX_RDATA: begin
                        if (rem_q == '0) state_next  = RX_HDR;
                        else             load_next_c = 1'b1;
                    end
                    default:  state_next = RX_HDR;
                endcase
            end
        end
    end

    // Frame datapath: receive shifter, header/address capture, tx shifter, timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt       <= '0;
            shift_q       <= '0;
            hdr_q         <= '0;
            addr_q        <= '0;
            rem_q         <= '0;
            tx_q          <= '0;
            timer_q       <= '0;
            serial_out_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            bit_cnt       <= bit_cnt_next;
            busy_q        <= (state_next != RX_HDR) || (bit_cnt_next != '0);
            frame_error_q <= timeout_c;
            if (rise_c) shift_q <= byte_c[REG_WIDTH-2:0];
            if (rise_c || !active_c) timer_q <= '0;
            else                     timer_q <= TW'(timer_q + 1'b1);
            if (byte_done_c && state == RX_HDR) hdr_q <= byte_c;
            if (byte_done_c && state == RX_ADDR) begin
                addr_q <= AW'(byte_c);
                rem_q  <= hdr_q[CW-1:0];
            end
            if (load_first_c) begin
                tx_q <= regs[AW'(byte_c)];
            end else if (load_next_c) begin
                tx_q   <= regs[AW'(addr_q + 1'b1)];
                addr_q <= AW'(addr_q + 1'b1);
                rem_q  <= CW'(rem_q - 1'b1);
            end else if (fall_c && state == TX_RDATA) begin
                tx_q <= {tx_q[REG_WIDTH-2:0], 1'b0};
            end
            if (state != TX_RDATA || state_next != TX_RDATA) serial_out_q <= 1'b0;
            else if (fall_c)                                 serial_out_q <= tx_q[REG_WIDTH-1];
        end
    end

    // Register bank and write-event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_pulse_q <= commit_c;
            if (commit_c) begin
                regs[addr_q] <= byte_c;
                wr_addr_q    <= 8'(addr_q);
                wr_data_q    <= byte_c;
            end
        end
    end

    assign bus.reg_rd_data  = regs[AW'(bus.reg_rd_addr)];
    assign bus.serial_out   = serial_out_q;
    assign bus.busy         = busy_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.reg_wr_pulse = wr_pulse_q;
    assign bus.reg_wr_addr  = wr_addr_q;
    assign bus.reg_wr_data  = wr_data_q;
endmodule

// File: tb/tb_spi_reg_target.sv
// Scoreboard bench for spi_reg_target: drives SPI mode-0 frames and compares
// returned read bytes and write strobes against a register-bank model.
module tb_spi_reg_target;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    spi_reg_target_if bus ();

    spi_reg_target dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  mdl [256];
    logic [7:0]  exp_rd_q [$];
    logic [15:0] exp_wr_q [$];

    // Write-strobe and frame-error log written only by this monitor.
    logic [15:0] wr_log [64];
    int          wr_cnt = 0;
    int          ferr_cnt = 0;
    int          wr_rd_idx = 0;

    always @(negedge clk) begin
        if (bus.reg_wr_pulse) begin
            if (wr_cnt < 64) wr_log[wr_cnt] <= {bus.reg_wr_addr, bus.reg_wr_data};
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.frame_error) ferr_cnt <= ferr_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            bus.serial_in = tx[7-i];
            repeat (HALF) @(negedge clk);
            rx = {rx[6:0], bus.serial_out};
            bus.spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic send_write(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] rx;
        spi_bits(8'h80, 8, rx);
        spi_bits(addr, 8, rx);
        spi_bits(data, 8, rx);
        mdl[addr] = data;
        exp_wr_q.push_back({addr, data});
    endtask

    task automatic send_read(input logic [7:0] hdr, input logic [7:0] addr, input string name);
        logic [7:0] rx, exp;
        int cnt;
        cnt = int'(hdr[6:0]) + 1;
        for (int i = 0; i < cnt; i++) exp_rd_q.push_back(mdl[8'(int'(addr) + i)]);
        spi_bits(hdr, 8, rx);
        spi_bits(addr, 8, rx);
        for (int i = 0; i < cnt; i++) begin
            spi_bits(8'h00, 8, rx);
            exp = exp_rd_q.pop_front();
            vectors++;
            if (rx !== exp) begin
                miscompares++;
                $display("FAIL %s byte %0d: got %02h expected %02h", name, i, rx, exp);
            end
        end
    endtask

    task automatic check_writes(input string name);
        logic [15:0] exp;
        repeat (4) @(negedge clk);
        vectors++;
        if (wr_cnt - wr_rd_idx !== exp_wr_q.size()) begin
            miscompares++;
            $display("FAIL %s write count: got %0d expected %0d", name, wr_cnt - wr_rd_idx,
                     exp_wr_q.size());
        end
        while (exp_wr_q.size() > 0 && wr_rd_idx < wr_cnt) begin
            exp = exp_wr_q.pop_front();
            vectors++;
            if (wr_log[wr_rd_idx] !== exp) begin
                miscompares++;
                $display("FAIL %s write addr/data: got %04h expected %04h", name,
                         wr_log[wr_rd_idx], exp);
            end
            wr_rd_idx++;
        end
        exp_wr_q.delete();
        wr_rd_idx = wr_cnt;
    endtask

    task automatic check_fabric(input logic [7:0] addr, input string name);
        bus.reg_rd_addr = addr;
        #1;
        vectors++;
        if (bus.reg_rd_data !== mdl[addr]) begin
            miscompares++;
            $display("FAIL %s reg_rd_data[%02h]: got %02h expected %02h", name, addr,
                     bus.reg_rd_data, mdl[addr]);
        end
    endtask

    task automatic check_busy(input logic exp, input string name);
        vectors++;
        if (bus.busy !== exp) begin
            miscompares++;
            $display("FAIL %s busy: got %b expected %b", name, bus.busy, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.spi_clk = 1'b0;
        bus.serial_in = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        logic [21:0] got;
        int bad;
        got = {bus.serial_out, bus.busy, bus.reg_wr_pulse, bus.frame_error,
               bus.reg_wr_addr, bus.reg_wr_data, 2'b00};
        vectors++;
        if (got !== 22'h0) begin
            miscompares++;
            $display("FAIL %s outputs {so,busy,wp,fe,waddr,wdata}: got %06h expected 000000",
                     name, got);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            bus.reg_rd_addr = 8'(i);
            #1;
            if (bus.reg_rd_data !== 8'h00) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s registers nonzero: got %0d expected 0", name, bad);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        send_write(8'h12, 8'h5A);
        check_writes("write");
        check_fabric(8'h12, "write");
        check_busy(1'b0, "write idle");
    endtask

    task automatic test_read();
        send_write(8'h10, 8'h11);
        send_write(8'h11, 8'h22);
        send_write(8'h12, 8'h33);
        check_writes("read preload");
        send_read(8'h02, 8'h10, "read burst");
        check_writes("read no write");
    endtask

    task automatic test_wrap();
        send_write(8'hFF, 8'hA1);
        send_write(8'h00, 8'hB2);
        check_writes("wrap preload");
        send_read(8'h01, 8'hFF, "read wrap");
    endtask

    task automatic test_timeout();
        logic [7:0] rx;
        int ferr0;
        ferr0 = ferr_cnt;
        spi_bits(8'h80, 8, rx);
        spi_bits(8'h03, 4, rx);
        check_busy(1'b1, "timeout mid-frame");
        repeat (1100) @(negedge clk);
        vectors++;
        if (ferr_cnt - ferr0 !== 1) begin
            miscompares++;
            $display("FAIL timeout frame_error pulses: got %0d expected 1", ferr_cnt - ferr0);
        end
        check_busy(1'b0, "timeout abort");
        check_writes("timeout no write");
        send_write(8'h03, 8'h77);
        check_writes("post-timeout write");
        check_fabric(8'h03, "post-timeout write");
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        send_write(8'h05, 8'h9C);
        check_writes("mid-read preload");
        spi_bits(8'h03, 8, rx);
        spi_bits(8'h04, 8, rx);
        spi_bits(8'h00, 3, rx);
        do_reset();
        check_reset_outputs("mid-read reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_read(8'h00, 8'h05, "read after reset");
    endtask

    task automatic test_back_to_back();
        send_write(8'h20, 8'hC3);
        send_read(8'h00, 8'h20, "back-to-back read");
        check_writes("back-to-back write");
    endtask

    initial begin
        bus.spi_clk = 1'b0;
        bus.serial_in = 1'b0;
        bus.reg_rd_addr = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_timeout();
        test_reset_mid_read();
        test_back_to_back();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_reg_target.md
Name: spi_reg_target

Overview:
- SPI target (responder) holding a register bank.
- Answers the single-byte write and burst read transactions issued by the team's SPI controller driver.
- Sits at the far end of the control-board SPI link: in an on-chip loopback bench, or in a companion FPGA emulating a front-end ASIC.
- Oversamples the SPI lines with the system clock, decodes frames, updates registers, shifts read data back.
- Exposes a fabric-side read port and a write-event strobe.

Parameters:
- REG_WIDTH, 8, bits per register, address and header byte width
- NUM_REGS, 256, register count; address wraps modulo NUM_REGS (power of two)
- TIMEOUT_CYCLES, 1024, clk cycles without an sclk rising edge mid-frame before abort

Ports:
- clk  in  1  system clock, at least 8x sclk frequency
- rst  in  1  synchronous, active-high reset
- spi_clk  in  1  SPI clock from controller, idle low, asynchronous to clk
- serial_in  in  1  controller-to-target data (MOSI)
- serial_out  out  1  target-to-controller data (MISO)
- reg_rd_addr  in  8  fabric read address
- reg_rd_data  out  REG_WIDTH  combinational contents of reg[reg_rd_addr]
- reg_wr_pulse  out  1  one-cycle strobe when an SPI write commits
- reg_wr_addr  out  8  address of the committed write
- reg_wr_data  out  REG_WIDTH  data of the committed write
- busy  out  1  high while a frame is in progress
- frame_error  out  1  one-cycle pulse on timeout abort

Behaviour:
- Synchronisation:
  - spi_clk and serial_in pass through 2-flop synchronisers.
  - Rise and fall events are detected from the synchronised spi_clk.
- SPI mode 0, MSB first:
  - Target samples serial_in on each rising event.
  - Target updates serial_out on each falling event.
- Frame format:
  - Byte0 is the header. bit7=1 means write; bit7=0 means read with count = bits6:0 + 1 (1..128).
  - Byte1 is the start address.
  - Write frames carry byte2 = data.
  - Read frames shift out count bytes: reg[addr], reg[addr+1], ..., wrapping modulo NUM_REGS.
- States:
  - RX_HDR: after 8 rise events, latch header and go to RX_ADDR.
  - RX_ADDR: after 8 rise events, latch address. A write goes to RX_WDATA. A read preloads reg[addr] into the tx shift register and goes to TX_RDATA.
  - RX_WDATA: after 8 rise events, commit the write, then go to RX_HDR.
  - TX_RDATA:
    - Count 8 rise events per byte.
    - At each byte boundary, decrement the remaining count, increment the address (wrap), and load the next register.
    - When the remaining count reaches 0, go to RX_HDR.
- serial_out timing:
  - In TX_RDATA, the MSB is driven on the falling event that follows the last address-byte rise.
  - Subsequent bits are driven on each following falling event.
  - Outside TX_RDATA, serial_out = 0.
- Write commit:
  - reg[addr] updates on the cycle after the 8th data rise event.
  - In that same cycle, reg_wr_pulse=1 for exactly one cycle, with reg_wr_addr and reg_wr_data valid.
- busy:
  - High from the first rise event of a header until return to RX_HDR.
  - Low in RX_HDR with zero bits received.
- Timeout:
  - Any state with bits received, or any state past RX_HDR, that sees no rise event for TIMEOUT_CYCLES clk cycles aborts.
  - Abort clears the bit counter, pulses frame_error for one cycle, returns to RX_HDR, and does no register write.
  - The counter reloads on every rise event.
- Reset:
  - Registers clear to 0; state goes to RX_HDR; counters clear.
  - Outputs go to 0: serial_out=0, busy=0, reg_wr_pulse=0, reg_wr_addr=0, reg_wr_data=0, frame_error=0.
  - Reset mid-frame discards the frame; the next frame must start with a header.
- Simultaneous fabric read and SPI commit to the same address: reg_rd_data shows the old value until the commit cycle, then the new value.
- Frames are back-to-back capable: a header bit may arrive on the rise event immediately after the prior frame's final bit.

Test Plan:
- Write header 0x80, addr 0x12, data 0x5A -> one reg_wr_pulse with addr 0x12 and data 0x5A; reg_rd_data at 0x12 = 0x5A; busy low after.
- Preload 0x10=0x11, 0x11=0x22, 0x12=0x33; read header 0x02, addr 0x10 -> serial_out bytes 0x11, 0x22, 0x33, MSB first; no reg_wr_pulse.
- Preload 0xFF=0xA1, 0x00=0xB2; read header 0x01, addr 0xFF -> bytes 0xA1, 0xB2 (address wrap).
- Send header 0x80 and 4 addr bits, then idle >1024 clk cycles -> one frame_error pulse, no write; then a full write to 0x03=0x77 succeeds.
- Assert rst mid read burst -> serial_out=0, busy=0, reg[all]=0; next read of 0x05 returns 0x00.
- Back-to-back write 0x20=0xC3 then read count 1 at 0x20 with no idle gap -> read returns 0xC3.
